divider_param: RTL

//   Parametrised multi-cycle integer divider; successor to the fixed 32-bit unsigned divider.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 32 +++
 rtl/divider_param.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the parametrised divider: FSM encoding and
// width-generic constant helpers for the signed minimum and all-ones values.
package div_pkg;

    // Widest operand the constant helpers can describe.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } div_state_t;

    // Most negative two's-complement value of the given width (only the MSB set).
    function automatic logic [MAX_WIDTH-1:0] min_val(input int width);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

    // All-ones value of the given width; quotient reported on divide-by-zero.
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits. The shifted remainder is
// one bit wider than the operands so the compare never loses the carry.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    // Trial subtraction; keep the difference only when the divisor fits.
    always_comb begin
        w_shift = {i_rem, i_bit};
        w_diff  = w_shift - {1'b0, i_divisor};
        w_fits  = (w_shift >= {1'b0, i_divisor});
        if (w_fits) begin
            o_rem  = w_diff[WIDTH-1:0];
            o_qbit = 1'b1;
        end else begin
            o_rem  = w_shift[WIDTH-1:0];
            o_qbit = 1'b0;
        end
    end

endmodule

// File: rtl/divider_param.sv
// Parametrised multi-cycle integer divider (restoring, one quotient bit per
// cycle) with per-operation signed mode, sticky ok/err flags and busy.
// Signed operations divide magnitudes and fix the signs up in a final cycle
// (truncating division: the remainder follows the dividend's sign).
module divider_param
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err,
    output logic             busy
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(min_val(WIDTH));
    localparam logic [WIDTH-1:0] ONES_W   = WIDTH'(all_ones(WIDTH));
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;

    logic             w_mode;
    logic             w_div_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_step_rem;
    logic             w_step_q;

    // Two's-complement negate when requested; used for |x| and the sign fixup.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        if (neg) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    assign w_mode     = is_signed & SIGNED_EN;
    assign w_div_zero = (B == {WIDTH{1'b0}});
    assign w_ovf      = w_mode && (A == MIN_W) && (B == ONES_W);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_bit    (r_quo[WIDTH-1]),
        .i_divisor(r_div),
        .o_rem    (w_step_rem),
        .o_qbit   (w_step_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: error operations never leave IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !w_div_zero && !w_ovf) begin
                    w_next_state = ST_CALC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = ST_FIXUP;
                end else begin
                    w_next_state = ST_CALC;
                end
            end
            ST_FIXUP: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Datapath, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_rem   <= {WIDTH{1'b0}};
            r_quo   <= {WIDTH{1'b0}};
            r_div   <= {WIDTH{1'b0}};
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            D       <= {WIDTH{1'b0}};
            R       <= {WIDTH{1'b0}};
            ok      <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        ok <= 1'b0;
                        if (w_div_zero) begin
                            D   <= ONES_W;
                            R   <= A;
                            err <= 1'b1;
                        end else if (w_ovf) begin
                            D   <= MIN_W;
                            R   <= {WIDTH{1'b0}};
                            err <= 1'b1;
                        end else begin
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            r_quo   <= cond_neg(A, w_mode & A[WIDTH-1]);
                            r_div   <= cond_neg(B, w_mode & B[WIDTH-1]);
                            r_rem   <= {WIDTH{1'b0}};
                            r_cnt   <= CNT_LAST;
                            r_neg_q <= w_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg_r <= w_mode & A[WIDTH-1];
                        end
                    end
                end
                ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_FIXUP: begin
                    D    <= cond_neg(r_quo, r_neg_q);
                    R    <= cond_neg(r_rem, r_neg_r);
                    ok   <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
